// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider width, iteration count and FSM state type.
package cpu_defs;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned DIV_ITERS = WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU, one quotient bit per cycle.
// Results are registered and held in DONE until the E stage is released.
module div_unit #(
    parameter int unsigned WIDTH = cpu_defs::WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             e_stall,
    input  logic             flush,
    output logic             ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    import cpu_defs::*;

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] part_q, part_d;   // partial remainder, then final remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0] div_q, div_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_step, quo_step;

    assign a_mag = (sign && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sign && b[WIDTH-1]) ? -b : b;

    // Restoring step: trial-subtract divisor from the shifted partial remainder.
    assign shifted  = {part_q, quo_q[WIDTH-1]};
    assign borrow   = shifted < {1'b0, div_q};
    assign diff     = shifted[WIDTH-1:0] - div_q;
    assign rem_step = borrow ? shifted[WIDTH-1:0] : diff;
    assign quo_step = {quo_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        part_d     = part_q;
        quo_d      = quo_q;
        div_d      = div_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        cnt_d      = '0;
                        div_d      = b_mag;
                        quot_neg_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_d  = sign & a[WIDTH-1];
                        if (b == '0) begin
                            quo_d   = '1;
                            part_d  = a;
                            state_d = DONE;
                        end else begin
                            quo_d   = a_mag;
                            part_d  = '0;
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        // Sign correction folds into the last step so DONE sees final values.
                        quo_d   = quot_neg_q ? -quo_step : quo_step;
                        part_d  = rem_neg_q ? -rem_step : rem_step;
                        state_d = DONE;
                    end else begin
                        quo_d  = quo_step;
                        part_d = rem_step;
                    end
                end
                DONE: begin
                    if (!e_stall) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            part_q     <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            part_q     <= part_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

    assign ready = (state_q == DONE);
    assign quot  = quo_q;
    assign rem   = part_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operations against an arithmetic reference model.
module tb_div_unit;

    localparam int W     = 32;
    localparam int LIMIT = 100;

    logic         clk = 1'b0;
    logic         resetn;
    logic         en, sign, e_stall, flush;
    logic [W-1:0] a, b;
    logic         ready;
    logic [W-1:0] quot, rem;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .e_stall(e_stall),
        .flush  (flush),
        .ready  (ready),
        .quot   (quot),
        .rem    (rem)
    );

    always #5 clk = ~clk;

    // Reference: divide magnitudes in 64-bit arithmetic, then apply MIPS sign rules.
    function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint mx, my, qq, rr;
        if (y == 0) begin
            q = '1;
            r = x;
            return;
        end
        mx = (s && x[W-1]) ? -longint'($signed(x)) : longint'(x);
        my = (s && y[W-1]) ? -longint'($signed(y)) : longint'(y);
        qq = mx / my;
        rr = mx % my;
        if (s && (x[W-1] ^ y[W-1])) qq = -qq;
        if (s && x[W-1]) rr = -rr;
        q = W'(qq);
        r = W'(rr);
    endfunction

    function automatic int exp_latency(input logic [W-1:0] y);
        return (y == 0) ? 1 : W + 1;
    endfunction

    // Present one request for one cycle; operands are scrambled afterwards.
    task automatic start_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        en   = 1'b1;
        sign = s;
        a    = x;
        b    = y;
        @(negedge clk);
        en   = 1'b0;
        sign = 1'($urandom);
        a    = $urandom;
        b    = $urandom;
    endtask

    task automatic wait_ready(output int lat);
        lat = 1;
        while (ready !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic s, input logic [W-1:0] x,
                            input logic [W-1:0] y);
        int lat;
        logic [W-1:0] eq, er;
        model(s, x, y, eq, er);
        start_op(s, x, y);
        wait_ready(lat);
        n_checks++;
        if (lat !== exp_latency(y)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_latency(y));
        end
        n_checks++;
        if (quot !== eq) begin
            n_fail++;
            $display("FAIL %s quot: got %h want %h (s=%0d a=%h b=%h)", name, quot, eq, s, x, y);
        end
        n_checks++;
        if (rem !== er) begin
            n_fail++;
            $display("FAIL %s rem: got %h want %h (s=%0d a=%h b=%h)", name, rem, er, s, x, y);
        end
    endtask

    task automatic check_no_ready(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL %s spurious ready: got %0d cycles want 0", name, seen);
        end
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b want 0", ready); end
        n_checks++;
        if (quot !== '0) begin n_fail++; $display("FAIL reset quot: got %h want 0", quot); end
        n_checks++;
        if (rem !== '0) begin n_fail++; $display("FAIL reset rem: got %h want 0", rem); end
        @(negedge clk);
        resetn = 1'b1;
        check_no_ready("reset_idle", 3);
    endtask

    task automatic test_directed;
        check_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_100_7 ready after done: got %b want 0", ready);
        end
        check_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("divu_5_0", 1'b0, 32'd5, 32'd0);
        check_op("div_neg_0", 1'b1, 32'hFFFF_FF00, 32'd0);
        check_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        check_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_random;
        logic [W-1:0] x, y;
        logic s;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            x = (($urandom & 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1:       y = 32'hFFFF_FFFF;
                2, 3:    y = $urandom_range(1, 15);
                default: y = $urandom >> $urandom_range(0, 31);
            endcase
            check_op("random", s, x, y);
        end
    endtask

    task automatic test_flush;
        start_op(1'b0, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush ready: got %b want 0", ready);
        end
        check_no_ready("flush", 40);
        check_op("after_flush_9_3", 1'b0, 32'd9, 32'd3);
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [W-1:0] q0, r0;
        start_op(1'b0, 32'd1000, 32'd3);
        wait_ready(lat);
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++;
            $display("FAIL stall latency: got %0d want %0d", lat, W + 1);
        end
        q0 = quot;
        r0 = rem;
        e_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin
                e_stall = 1'b0;
                en      = 1'b1;
                sign    = 1'b0;
                a       = 32'd8;
                b       = 32'd2;
            end
            n_checks++;
            if (ready !== 1'b1 || quot !== q0 || rem !== r0) begin
                n_fail++;
                $display("FAIL stall hold %0d: got ready=%b q=%h r=%h want ready=1 q=%h r=%h",
                         i, ready, quot, rem, q0, r0);
            end
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back gap ready: got %b want 0", ready);
        end
        @(negedge clk);
        en = 1'b0;
        a  = $urandom;
        b  = $urandom;
        wait_ready(lat);
        n_checks++;
        if (lat !== W + 1 || quot !== 32'd4 || rem !== 32'd0) begin
            n_fail++;
            $display("FAIL back_to_back 8/2: got lat=%0d q=%h r=%h want lat=%0d q=4 r=0",
                     lat, quot, rem, W + 1);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        start_op(1'b1, 32'hDEAD_BEEF, 32'd12345);
        repeat (19) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || quot !== '0 || rem !== '0) begin
            n_fail++;
            $display("FAIL reset_busy: got ready=%b q=%h r=%h want 0 0 0", ready, quot, rem);
        end
        @(negedge clk);
        resetn = 1'b1;
        check_no_ready("reset_busy", 40);

        start_op(1'b0, 32'd1000, 32'd3);
        wait_ready(lat);
        e_stall = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || quot !== 32'd333) begin
            n_fail++;
            $display("FAIL done_before_reset: got ready=%b q=%h want ready=1 q=14d", ready, quot);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || quot !== '0 || rem !== '0) begin
            n_fail++;
            $display("FAIL reset_done: got ready=%b q=%h r=%h want 0 0 0", ready, quot, rem);
        end
        @(negedge clk);
        resetn  = 1'b1;
        e_stall = 1'b0;
        check_no_ready("reset_done", 40);
        check_op("after_reset", 1'b1, 32'hFFFF_FF9C, 32'd7);
    endtask

    initial begin
        resetn  = 1'b0;
        en      = 1'b0;
        sign    = 1'b0;
        a       = '0;
        b       = '0;
        e_stall = 1'b0;
        flush   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
